// File: rtl/latch_write_sched_if.sv
// latch_write_sched_if: requester-side request/data and latch-side outputs of the scheduler
interface latch_write_sched_if #(
  parameter int NREQ = 4,
  parameter int DW = 8,
  parameter int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0] req;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic [DW-1:0] lat_din;
  logic lat_en;
  logic busy;
  logic [IDW-1:0] last_id;
  modport master(output req, wdata, input gnt, done, lat_din, lat_en, busy, last_id);
  modport slave(input req, wdata, output gnt, done, lat_din, lat_en, busy, last_id);
endinterface

// File: rtl/latch_write_sched.sv
// latch_write_sched: round-robin writer sharing one D-latch word with setup/open/hold sequencing
module latch_write_sched #(
  parameter int NREQ = 4,
  parameter int DW = 8,
  parameter int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input logic clk,
  input logic rst_n,
  latch_write_sched_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SETUP, OPEN, HOLD, DONE} state_t;
  state_t state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  // scan downward so the requester closest to ptr is assigned last and wins
  always_comb begin
    win = ptr;
    for (int k = NREQ - 1; k >= 0; k--)
      if (bus.req[(int'(ptr) + k) % NREQ]) win = IDW'((int'(ptr) + k) % NREQ);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      bus.gnt <= '0;
      bus.done <= '0;
      bus.lat_din <= '0;
      bus.lat_en <= 1'b0;
      bus.busy <= 1'b0;
      bus.last_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= '0;
          if (|bus.req) begin
            bus.gnt <= NREQ'(1) << win;
            bus.lat_din <= bus.wdata[int'(win)*DW +: DW];
            bus.last_id <= win;
            bus.busy <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: state <= OPEN;
        OPEN: begin
          bus.lat_en <= 1'b1;
          state <= HOLD;
        end
        HOLD: begin
          bus.lat_en <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          bus.done <= bus.gnt;
          bus.gnt <= '0;
          bus.busy <= 1'b0;
          ptr <= IDW'((int'(bus.last_id) + 1) % NREQ);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
